// File: rtl/rx_cmd_sequencer_pkg.sv
// Shared encodings for the rx command sequencer: command types, per-command
// bit lengths, FSM states and the received-data width.
package rx_cmd_sequencer_pkg;

  localparam int DATA_W = 40;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_QUERYREP = 3'd1,
    CMD_ACK      = 3'd2,
    CMD_QUERY    = 3'd3,
    CMD_QUERYADJ = 3'd4,
    CMD_NAK      = 3'd5,
    CMD_REQRN    = 3'd6
  } cmd_type_t;

  localparam logic [CNT_W-1:0] LEN_QUERYREP = 6'd4;
  localparam logic [CNT_W-1:0] LEN_ACK      = 6'd18;
  localparam logic [CNT_W-1:0] LEN_QUERY    = 6'd22;
  localparam logic [CNT_W-1:0] LEN_QUERYADJ = 6'd9;
  localparam logic [CNT_W-1:0] LEN_NAK      = 6'd8;
  localparam logic [CNT_W-1:0] LEN_REQRN    = 6'd40;

  // state     | meaning
  // ST_IDLE   | waiting for the first bit of a command
  // ST_RECV   | shifting bits in, length decoded from the prefix
  // ST_DONE   | complete command held until cmd_ack
  // ST_RESYNC | rx_reset held high to re-arm the receiver
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_DONE   = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/rx_cmd_sequencer_length_decode.sv
// Prefix decoder: given the low received bits and the bit count they
// represent, reports the command length/type once the prefix determines it,
// or flags an illegal prefix. Produces nothing at counts where the prefix is
// still ambiguous.
module cmd_length_decode
  import rx_cmd_sequencer_pkg::*;
(
  input  logic [7:0]       prefix,
  input  logic [CNT_W-1:0] bitcount,
  output logic             len_valid,
  output logic [CNT_W-1:0] exp_len,
  output cmd_type_t        cmd_type,
  output logic             decode_error
);

  // Decide the command from 2-, 4- or 8-bit prefixes.
  always_comb begin
    len_valid    = 1'b0;
    exp_len      = '0;
    cmd_type     = CMD_NONE;
    decode_error = 1'b0;
    case (bitcount)
      6'd2: begin
        if (prefix[1:0] == 2'b00) begin
          len_valid = 1'b1;
          exp_len   = LEN_QUERYREP;
          cmd_type  = CMD_QUERYREP;
        end else if (prefix[1:0] == 2'b01) begin
          len_valid = 1'b1;
          exp_len   = LEN_ACK;
          cmd_type  = CMD_ACK;
        end
      end
      6'd4: begin
        if (prefix[3:2] == 2'b10) begin
          if (prefix[1:0] == 2'b00) begin
            len_valid = 1'b1;
            exp_len   = LEN_QUERY;
            cmd_type  = CMD_QUERY;
          end else if (prefix[1:0] == 2'b01) begin
            len_valid = 1'b1;
            exp_len   = LEN_QUERYADJ;
            cmd_type  = CMD_QUERYADJ;
          end else begin
            decode_error = 1'b1;
          end
        end
      end
      6'd8: begin
        if (prefix[7:6] == 2'b11) begin
          if (prefix[5:0] == 6'b000000) begin
            len_valid = 1'b1;
            exp_len   = LEN_NAK;
            cmd_type  = CMD_NAK;
          end else if (prefix[5:0] == 6'b000001) begin
            len_valid = 1'b1;
            exp_len   = LEN_REQRN;
            cmd_type  = CMD_REQRN;
          end else begin
            decode_error = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_cmd_sequencer.sv
// Collects serial rx bits into a command, decodes its type/length from the
// prefix, holds the result for a consumer and re-arms the receiver via
// rx_reset after completion, decode errors or overflows.
module rx_cmd_sequencer
  import rx_cmd_sequencer_pkg::*;
#(
  parameter int RESYNC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bitin,
  input  logic              bitclk,
  input  logic              rx_overflow_reset,
  input  logic              cmd_ack,
  output logic              rx_reset,
  output logic              cmd_valid,
  output logic [2:0]        cmd_type,
  output logic [5:0]        cmd_len,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_error
);

  localparam int RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic [CNT_W-1:0]  exp_len_q, exp_len_n;
  cmd_type_t         exp_type_q, exp_type_n;
  cmd_type_t         type_q, type_n;
  logic [CNT_W-1:0]  len_q, len_n;
  logic              valid_q, valid_n;
  logic              rx_reset_q, rx_reset_n;
  logic              error_q, error_n;
  logic [RW-1:0]     resync_q, resync_n;
  logic              bitclk_d;

  logic              bit_event;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  count_inc;
  logic              dec_valid, dec_err;
  logic [CNT_W-1:0]  dec_len, eff_len;
  cmd_type_t         dec_type, eff_type;
  logic              go_resync, go_clear;

  assign bit_event = bitclk & ~bitclk_d;
  assign shifted   = {data_q[DATA_W-2:0], bitin};
  assign count_inc = count_q + 6'd1;

  cmd_length_decode u_decode (
    .prefix       (shifted[7:0]),
    .bitcount     (count_inc),
    .len_valid    (dec_valid),
    .exp_len      (dec_len),
    .cmd_type     (dec_type),
    .decode_error (dec_err)
  );

  // A length decoded on this edge must count already, so NAK completes at 8.
  assign eff_len  = dec_valid ? dec_len  : exp_len_q;
  assign eff_type = dec_valid ? dec_type : exp_type_q;

  // Next-state and next-output logic; overflow always beats a bit event.
  always_comb begin
    state_n    = state_q;
    data_n     = data_q;
    count_n    = count_q;
    exp_len_n  = exp_len_q;
    exp_type_n = exp_type_q;
    type_n     = type_q;
    len_n      = len_q;
    valid_n    = valid_q;
    rx_reset_n = rx_reset_q;
    error_n    = 1'b0;
    resync_n   = resync_q;
    go_resync  = 1'b0;
    go_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_overflow_reset) begin
          go_resync = 1'b1;
        end else if (bit_event) begin
          state_n = ST_RECV;
          data_n  = DATA_W'(bitin);
          count_n = 6'd1;
        end
      end
      ST_RECV: begin
        if (rx_overflow_reset) begin
          go_resync = 1'b1;
          error_n   = 1'b1;
        end else if (bit_event) begin
          data_n     = shifted;
          count_n    = count_inc;
          exp_len_n  = eff_len;
          exp_type_n = eff_type;
          if (dec_err) begin
            go_resync = 1'b1;
            error_n   = 1'b1;
          end else if (eff_len != '0 && count_inc == eff_len) begin
            state_n    = ST_DONE;
            valid_n    = 1'b1;
            rx_reset_n = 1'b1;
            type_n     = eff_type;
            len_n      = count_inc;
          end
        end
      end
      ST_DONE: begin
        if (cmd_ack) begin
          state_n = ST_IDLE;
          go_clear = 1'b1;
        end
      end
      ST_RESYNC: begin
        if (resync_q == '0) begin
          state_n    = ST_IDLE;
          rx_reset_n = 1'b0;
        end else begin
          resync_n = resync_q - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (go_resync || go_clear) begin
      data_n     = '0;
      count_n    = '0;
      exp_len_n  = '0;
      exp_type_n = CMD_NONE;
      type_n     = CMD_NONE;
      len_n      = '0;
      valid_n    = 1'b0;
      rx_reset_n = 1'b0;
    end
    if (go_resync) begin
      state_n    = ST_RESYNC;
      rx_reset_n = 1'b1;
      resync_n   = RW'(RESYNC_CYCLES - 1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      count_q    <= '0;
      exp_len_q  <= '0;
      exp_type_q <= CMD_NONE;
      type_q     <= CMD_NONE;
      len_q      <= '0;
      valid_q    <= 1'b0;
      rx_reset_q <= 1'b0;
      error_q    <= 1'b0;
      resync_q   <= '0;
      bitclk_d   <= 1'b0;
    end else begin
      state_q    <= state_n;
      data_q     <= data_n;
      count_q    <= count_n;
      exp_len_q  <= exp_len_n;
      exp_type_q <= exp_type_n;
      type_q     <= type_n;
      len_q      <= len_n;
      valid_q    <= valid_n;
      rx_reset_q <= rx_reset_n;
      error_q    <= error_n;
      resync_q   <= resync_n;
      bitclk_d   <= bitclk;
    end
  end

  assign rx_reset  = rx_reset_q;
  assign cmd_valid = valid_q;
  assign cmd_type  = type_q;
  assign cmd_len   = len_q;
  assign cmd_data  = data_q;
  assign cmd_error = error_q;

endmodule
